id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register for the pipelined MIPS core. It sits between the decode stage (register file reads, sign extension, control decode) and the execute stage. It captures decoded operands and control, and detects load-use hazards so that a bubble can be inserted. It also bypasses a same-cycle write-back value, because the register file's read of that register would otherwise be stale. A saturating counter records how many load-use bubbles have been inserted.

## Interface
- `BUBBLE_CNT_W`, default 16: width of the load-use bubble counter.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: decode slot holds a real instruction.
- `id_pc_plus4` in 32: PC+4 of the decode instruction.
- `id_read_data1`, `id_read_data2` in 32: register file outputs for `rs` and `rt`.
- `id_imm` in 32: sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd` in 5: register specifiers.
- `id_uses_rt` in 1: the instruction reads `rt` as a source (R-type, store, branch).
- `id_reg_write`, `id_mem_to_reg`, `id_mem_read`, `id_mem_write`, `id_alu_src`, `id_reg_dst` in 1 each: decoded control.
- `id_alu_op` in 3: ALU operation class.
- `wb_reg_write` in 1, `wb_write_reg` in 5, `wb_write_data` in 32: write-back port, the same values that drive the register file.
- `flush` in 1: branch or jump taken; squash the decode instruction.
- `hold` in 1: downstream freeze (multicycle unit busy).
- `stall` out 1: combinational; freezes the PC and the IF/ID register.
- `ex_valid` out 1, plus `ex_pc_plus4`, `ex_read_data1`, `ex_read_data2`, `ex_imm`, `ex_rs`, `ex_rt`, `ex_rd` and all `ex_*` control outputs: registered copies of the corresponding `id_*` fields.
- `bubble_count` out `BUBBLE_CNT_W`: saturating count of load-use bubbles.

## Operation
- **Hazard term:** `hazard = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)))`.
- **Stall output:** `stall = hold | (hazard & ~flush)`. Under `flush` the decode instruction is dead, so no load-use stall is raised.
- **Update priority each rising edge, highest first:**
  - `hold`: every register keeps its value; `bubble_count` unchanged.
  - `flush`: load a bubble.
  - `hazard`: load a bubble; increment `bubble_count`, saturating at all-ones.
  - Otherwise: capture the `id_*` fields, with `ex_valid` = `id_valid`.
- **Bubble:** `ex_valid` = 0; all control outputs = 0; all data and specifier outputs = 0.
- **Write-back bypass on normal capture:**
  - `ex_read_data1` = `wb_write_data` if `wb_reg_write & (wb_write_reg != 0) & (wb_write_reg == id_rs)`; otherwise `id_read_data1`.
  - The same rule applies for `ex_read_data2` against `id_rt`. It applies regardless of `id_uses_rt`.
  - Register 0 is never bypassed.
- **Invalid decode slot:** when `id_valid` = 0 on a normal capture, all control outputs are forced to 0, so a non-valid slot can never write memory or registers.

## Timing
- **Reset:** `rst_n` low forces immediately, without waiting for `clk`: all `ex_*` outputs = 0, `ex_valid` = 0, `bubble_count` = 0.
  - `stall` is then 0 unless `hold` = 1.
  - Reset deassertion is synchronised externally; the first capture occurs on the first rising edge with `rst_n` high.
- **Latency:** one cycle from `id_*` to `ex_*`.
- **Load-use:** the hazard is seen in the cycle where the load sits in EX. The dependent instruction is held in ID for exactly one cycle, then captured normally on the next edge.
- **Hazard while held:** if `hold` is asserted while `hazard` is true, no bubble is inserted and the counter does not move. The hazard re-evaluates when `hold` drops.
- **Flush and hazard together:** a bubble is loaded, `bubble_count` is not incremented, and `stall` = 0.
- **Counter wrap:** at `bubble_count` = 2^W−1 further hazards leave it unchanged.
- **Reset mid-hold or mid-stall:** reset wins; the pipeline restarts empty.

## Test plan
- **Reset:** drive `id_*` nonzero and pulse `rst_n` low between edges → all `ex_*` = 0 immediately and `bubble_count` = 0; the first edge after release captures the `id_*` fields.
- **Load-use:** `lw` with `rt`=5 in EX; ID has `rs`=5 → `stall`=1 for one cycle, EX receives a bubble, `bubble_count`=1; the next edge captures the dependent instruction.
- **Bypass:** `id_rs`=3, `id_read_data1`=0x11, WB writes 0xABCD to r3 → `ex_read_data1`=0xABCD. Repeat with `wb_write_reg`=0 and `id_rs`=0 → `ex_read_data1` = `id_read_data1`.
- **Flush priority:** `flush`=1 together with an active hazard → bubble loaded, `stall`=0, `bubble_count` unchanged.
- **Hold:** `hold`=1 for 3 cycles while the `id_*` inputs change → `ex_*` values frozen and `stall`=1 throughout.
- **Saturation:** `BUBBLE_CNT_W`=2 with 5 consecutive load-use hazards → `bubble_count` sticks at 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: load-use hazard detection, write-back
// bypass into the captured operands, saturating bubble counter.
module id_ex_stage #(
    parameter int BUBBLE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [31:0]             id_pc_plus4,
    input  logic [31:0]             id_read_data1,
    input  logic [31:0]             id_read_data2,
    input  logic [31:0]             id_imm,
    input  logic [4:0]              id_rs,
    input  logic [4:0]              id_rt,
    input  logic [4:0]              id_rd,
    input  logic                    id_uses_rt,
    input  logic                    id_reg_write,
    input  logic                    id_mem_to_reg,
    input  logic                    id_mem_read,
    input  logic                    id_mem_write,
    input  logic                    id_alu_src,
    input  logic                    id_reg_dst,
    input  logic [2:0]              id_alu_op,
    input  logic                    wb_reg_write,
    input  logic [4:0]              wb_write_reg,
    input  logic [31:0]             wb_write_data,
    input  logic                    flush,
    input  logic                    hold,
    output logic                    stall,
    output logic                    ex_valid,
    output logic [31:0]             ex_pc_plus4,
    output logic [31:0]             ex_read_data1,
    output logic [31:0]             ex_read_data2,
    output logic [31:0]             ex_imm,
    output logic [4:0]              ex_rs,
    output logic [4:0]              ex_rt,
    output logic [4:0]              ex_rd,
    output logic                    ex_reg_write,
    output logic                    ex_mem_to_reg,
    output logic                    ex_mem_read,
    output logic                    ex_mem_write,
    output logic                    ex_alu_src,
    output logic                    ex_reg_dst,
    output logic [2:0]              ex_alu_op,
    output logic [BUBBLE_CNT_W-1:0] bubble_count
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc_plus4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dst;
        logic [2:0]  alu_op;
    } id_ex_t;

    localparam logic [BUBBLE_CNT_W-1:0] CNT_ONE =
        {{(BUBBLE_CNT_W-1){1'b0}}, 1'b1};

    id_ex_t                  ex_q;
    id_ex_t                  ex_d;
    id_ex_t                  cap;
    logic [BUBBLE_CNT_W-1:0] cnt_q;
    logic [BUBBLE_CNT_W-1:0] cnt_d;
    logic                    hazard;
    logic                    wb_fwd;
    logic                    byp1;
    logic                    byp2;

    always_comb begin
        hazard = ex_q.valid & ex_q.mem_read & (ex_q.rt != 5'd0) &
                 id_valid &
                 ((ex_q.rt == id_rs) |
                  (id_uses_rt & (ex_q.rt == id_rt)));
    end

    assign stall  = hold | (hazard & ~flush);
    assign wb_fwd = wb_reg_write & (wb_write_reg != 5'd0);
    assign byp1   = wb_fwd & (wb_write_reg == id_rs);
    assign byp2   = wb_fwd & (wb_write_reg == id_rt);

    // Normal capture; a non-valid slot never carries live control.
    always_comb begin
        cap          = '0;
        cap.valid    = id_valid;
        cap.pc_plus4 = id_pc_plus4;
        cap.rd1      = byp1 ? wb_write_data : id_read_data1;
        cap.rd2      = byp2 ? wb_write_data : id_read_data2;
        cap.imm      = id_imm;
        cap.rs       = id_rs;
        cap.rt       = id_rt;
        cap.rd       = id_rd;
        if (id_valid) begin
            cap.reg_write  = id_reg_write;
            cap.mem_to_reg = id_mem_to_reg;
            cap.mem_read   = id_mem_read;
            cap.mem_write  = id_mem_write;
            cap.alu_src    = id_alu_src;
            cap.reg_dst    = id_reg_dst;
            cap.alu_op     = id_alu_op;
        end
    end

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (!hold) begin
            if (flush) begin
                ex_d = '0;
            end else if (hazard) begin
                ex_d = '0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                ex_d = cap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_pc_plus4   = ex_q.pc_plus4;
    assign ex_read_data1 = ex_q.rd1;
    assign ex_read_data2 = ex_q.rd2;
    assign ex_imm        = ex_q.imm;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_reg_dst    = ex_q.reg_dst;
    assign ex_alu_op     = ex_q.alu_op;
    assign bubble_count  = cnt_q;

endmodule
